// File: rtl/ahb_params_pkg.sv
// Shared AHB decoder constants: slave address map, bus encodings,
// data-phase owner encoding and watchdog FSM states.
package ahb_params_pkg;

  localparam int unsigned NUM_SLAVES = 4;
  localparam int unsigned MAP_W      = 32;

  localparam logic [NUM_SLAVES-1:0][MAP_W-1:0] SLV_BASE = {
    32'h3000_0000,
    32'h2000_0000,
    32'h1000_0000,
    32'h0000_0000
  };

  localparam logic [NUM_SLAVES-1:0][MAP_W-1:0] SLV_MASK = {
    32'hF000_0000,
    32'hF000_0000,
    32'hF000_0000,
    32'hF000_0000
  };

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_S0   = 3'd1,
    DSEL_S1   = 3'd2,
    DSEL_S2   = 3'd3,
    DSEL_S3   = 3'd4,
    DSEL_DEF  = 3'd5
  } dsel_e;

  typedef enum logic [1:0] {
    TO_IDLE = 2'd0,
    TO_ERR1 = 2'd1,
    TO_ERR2 = 2'd2
  } to_state_e;

  function automatic dsel_e slv_dsel(input int i);
    return dsel_e'(3'(i + 1));
  endfunction

endpackage

// File: rtl/ahb_timeout_fsm.sv
// Wait-state watchdog: after TIMEOUT_CYCLES consecutive stalled cycles
// it forces a two-cycle ERROR response (ERR1 then ERR2).
module ahb_timeout_fsm
  import ahb_params_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic busy_i,
  input  logic ready_i,
  output logic err1_o,
  output logic err2_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  to_state_e       state_q;
  logic [CW-1:0]   cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TO_IDLE;
      cnt_q   <= '0;
      err1_o  <= 1'b0;
      err2_o  <= 1'b0;
    end else begin
      unique case (state_q)
        TO_IDLE: begin
          if (busy_i && !ready_i) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
              state_q <= TO_ERR1;
              cnt_q   <= '0;
              err1_o  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        TO_ERR1: begin
          state_q <= TO_ERR2;
          err1_o  <= 1'b0;
          err2_o  <= 1'b1;
        end
        TO_ERR2: begin
          state_q <= TO_IDLE;
          err2_o  <= 1'b0;
        end
        default: begin
          state_q <= TO_IDLE;
          cnt_q   <= '0;
          err1_o  <= 1'b0;
          err2_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and response mux for a single-master bus.
// Define AHB_DECODER_TIMEOUT_EN to add the hung-slave watchdog.
module ahb_decoder_mux
  import ahb_params_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_SLAVES     = ahb_params_pkg::NUM_SLAVES,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL,
  output logic                         HSEL_DEFAULT,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [2*NUM_SLAVES-1:0]      HRESP_S,
  input  logic [DATA_W-1:0]            HRDATA_DEF,
  input  logic                         HREADY_DEF,
  input  logic [1:0]                   HRESP_DEF,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic [1:0]                   HRESP
);

  dsel_e             dec_tgt;
  dsel_e             dsel_d;
  dsel_e             dsel_q;
  logic              trans_valid;
  logic              mux_ready;
  logic [1:0]        mux_resp;
  logic [DATA_W-1:0] mux_rdata;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    HSEL    = '0;
    dec_tgt = DSEL_DEF;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[i][ADDR_W-1:0]) ==
          SLV_BASE[i][ADDR_W-1:0]) begin
        HSEL    = '0;
        HSEL[i] = 1'b1;
        dec_tgt = slv_dsel(i);
      end
    end
  end

  assign HSEL_DEFAULT = ~|HSEL;

  assign trans_valid = (HTRANS == HTRANS_NONSEQ) ||
                       (HTRANS == HTRANS_SEQ);
  assign dsel_d = trans_valid ? dec_tgt : DSEL_NONE;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= DSEL_NONE;
    end else if (HREADY) begin
      dsel_q <= dsel_d;
    end
  end

  always_comb begin
    mux_ready = 1'b1;
    mux_resp  = HRESP_OKAY;
    mux_rdata = '0;
    if (dsel_q == DSEL_DEF) begin
      mux_ready = HREADY_DEF;
      mux_resp  = HRESP_DEF;
      mux_rdata = HRDATA_DEF;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == slv_dsel(i)) begin
        mux_ready = HREADYOUT_S[i];
        mux_resp  = HRESP_S[2*i +: 2];
        mux_rdata = HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef AHB_DECODER_TIMEOUT_EN
  logic err1;
  logic err2;

  ahb_timeout_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .busy_i (dsel_q != DSEL_NONE),
    .ready_i(mux_ready),
    .err1_o (err1),
    .err2_o (err2)
  );

  always_comb begin
    HREADY = mux_ready;
    HRESP  = mux_resp;
    HRDATA = mux_rdata;
    unique case (1'b1)
      err1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
        HRDATA = '0;
      end
      err2: begin
        HREADY = 1'b1;
        HRESP  = HRESP_ERROR;
        HRDATA = '0;
      end
      default: ;
    endcase
  end
`else
  assign HREADY = mux_ready;
  assign HRESP  = mux_resp;
  assign HRDATA = mux_rdata;
`endif

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed scoreboard bench for ahb_decoder_mux; the watchdog
// steps run when AHB_DECODER_TIMEOUT_EN is defined.
module tb_ahb_decoder_mux;
  import ahb_params_pkg::*;

  localparam int DW = 32;
  localparam int NS = 4;

  localparam logic [31:0] W_S0  = 32'h1111_0004;
  localparam logic [31:0] W_S1  = 32'h2222_1111;
  localparam logic [31:0] W_S3  = 32'h3333_0008;
  localparam logic [31:0] W_DEF = 32'hDEAD_BEEF;
  localparam logic [31:0] W_RD  = 32'hCAFE_F00D;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [NS-1:0]    HSEL;
  logic             HSEL_DEFAULT;
  logic [NS*DW-1:0] HRDATA_S;
  logic [NS-1:0]    HREADYOUT_S;
  logic [2*NS-1:0]  HRESP_S;
  logic [DW-1:0]    HRDATA_DEF;
  logic             HREADY_DEF;
  logic [1:0]       HRESP_DEF;
  logic [DW-1:0]    HRDATA;
  logic             HREADY;
  logic [1:0]       HRESP;

  ahb_decoder_mux #(
    .ADDR_W(32),
    .DATA_W(DW),
    .NUM_SLAVES(NS),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HSEL_DEFAULT(HSEL_DEFAULT),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA_DEF  (HRDATA_DEF),
    .HREADY_DEF  (HREADY_DEF),
    .HRESP_DEF   (HRESP_DEF),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        chkd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d,
                      input logic [1:0] r,
                      input logic c);
    exp_t e;
    e.data = d;
    e.resp = r;
    e.chkd = c;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ready"}, 32'(HREADY), 32'd1);
      chk({tag, "_resp"}, 32'(HRESP), 32'(e.resp));
      if (e.chkd) chk({tag, "_data"}, HRDATA, e.data);
    end
  endtask

  initial begin
    HRESETn     = 1'b0;
    HADDR       = 32'h1000_0040;
    HTRANS      = HTRANS_IDLE;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    HRDATA_S[0*DW +: DW] = W_S0;
    HRDATA_S[1*DW +: DW] = W_S1;
    HRDATA_S[2*DW +: DW] = 32'h2222_0000;
    HRDATA_S[3*DW +: DW] = W_S3;
    HRDATA_DEF  = W_DEF;
    HREADY_DEF  = 1'b1;
    HRESP_DEF   = HRESP_ERROR;
    #2;
    chk("rst_hsel", 32'(HSEL), 32'b0010);
    chk("rst_hdef", 32'(HSEL_DEFAULT), 32'd0);
    chk("rst_ready", 32'(HREADY), 32'd1);
    chk("rst_resp", 32'(HRESP), 32'd0);
    chk("rst_data", HRDATA, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();

    // slave2 read with two wait states
    HADDR  = 32'h2000_0000;
    HTRANS = HTRANS_NONSEQ;
    HREADYOUT_S[2] = 1'b0;
    #1;
    chk("s2_hsel", 32'(HSEL), 32'b0100);
    chk("idle_ready", 32'(HREADY), 32'd1);
    push(W_RD, HRESP_OKAY, 1'b1);
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    chk("s2_ws1", 32'(HREADY), 32'd0);
    tick();
    chk("s2_ws2", 32'(HREADY), 32'd0);
    tick();
    HREADYOUT_S[2] = 1'b1;
    HRDATA_S[2*DW +: DW] = W_RD;
    #1;
    pop_chk("s2_rd");
    tick();

    // unmapped address goes to the default slave
    HADDR  = 32'h8000_0000;
    HTRANS = HTRANS_NONSEQ;
    #1;
    chk("def_hdef", 32'(HSEL_DEFAULT), 32'd1);
    chk("def_hsel", 32'(HSEL), 32'd0);
    push(W_DEF, HRESP_ERROR, 1'b1);
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    pop_chk("def");
    tick();

    // back-to-back slave0 then slave3
    HADDR  = 32'h0000_0004;
    HTRANS = HTRANS_NONSEQ;
    push(W_S0, HRESP_OKAY, 1'b1);
    tick();
    HADDR  = 32'h3000_0008;
    HTRANS = HTRANS_NONSEQ;
    push(W_S3, HRESP_OKAY, 1'b1);
    #1;
    pop_chk("b2b_s0");
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    pop_chk("b2b_s3");
    tick();

    // BUSY is treated as IDLE
    HADDR  = 32'h1000_0000;
    HTRANS = HTRANS_BUSY;
    HREADYOUT_S[1] = 1'b0;
    HRESP_S[3:2]   = HRESP_ERROR;
    #1;
    chk("busy_hsel", 32'(HSEL), 32'b0010);
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    chk("busy_ready", 32'(HREADY), 32'd1);
    chk("busy_resp", 32'(HRESP), 32'd0);
    chk("busy_data", HRDATA, 32'd0);
    HREADYOUT_S[1] = 1'b1;
    HRESP_S[3:2]   = HRESP_OKAY;
    tick();

    // slave0 hangs; the next address phase waits behind it
    HADDR  = 32'h0000_0010;
    HTRANS = HTRANS_NONSEQ;
    HREADYOUT_S[0] = 1'b0;
`ifdef AHB_DECODER_TIMEOUT_EN
    push(32'd0, HRESP_ERROR, 1'b0);
`endif
    tick();
    HADDR  = 32'h3000_0000;
    HTRANS = HTRANS_NONSEQ;
    #1;
`ifdef AHB_DECODER_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      chk("to_wait", 32'(HREADY), 32'd0);
      tick();
    end
    chk("err1_ready", 32'(HREADY), 32'd0);
    chk("err1_resp", 32'(HRESP), 32'(HRESP_ERROR));
    push(W_S3, HRESP_OKAY, 1'b1);
    tick();
    pop_chk("err2");
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    pop_chk("after_err");
    tick();
    HADDR  = 32'h0000_0000;
    HTRANS = HTRANS_NONSEQ;
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    for (int k = 0; k < 16; k++) begin
      tick();
    end
    chk("err1b_resp", 32'(HRESP), 32'(HRESP_ERROR));
`else
    for (int k = 0; k < 20; k++) begin
      chk("hang", 32'(HREADY), 32'd0);
      tick();
    end
`endif

    // asynchronous reset in the middle of a stalled data phase
    #1;
    HRESETn = 1'b0;
    HTRANS  = HTRANS_IDLE;
    #1;
    chk("arst_ready", 32'(HREADY), 32'd1);
    chk("arst_resp", 32'(HRESP), 32'd0);
    chk("arst_data", HRDATA, 32'd0);
    HREADYOUT_S[0] = 1'b1;
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();

    HADDR  = 32'h1000_0000;
    HTRANS = HTRANS_NONSEQ;
    push(W_S1, HRESP_OKAY, 1'b1);
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    pop_chk("recover_s1");
    chk("sb_empty", 32'(sb.size()), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
